// File: rtl/clk_enable_gen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// Holds the FSM state encoding, common 50 MHz increments and the select-width helper.
package clk_enable_gen_pkg;

    typedef enum logic [1:0] {
        RELOAD = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [31:0] INC_25M2_AT_50M = 32'd2164663517;
    localparam logic [31:0] INC_18M_AT_50M  = 32'd1546188227;

    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clk_enable_gen_channel.sv
// One DDS channel: shadow/active increment, phase accumulator, carry->enable and MSB output.
// Optional start phase is compiled in with CLKEN_GEN_PHASE_EN.
module clk_enable_gen_channel #(
    parameter int                   ACC_WIDTH = 32,
    parameter logic [ACC_WIDTH-1:0] INIT_INC  = '0
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 reload,
    input  logic                 run,
    input  logic                 wr_en,
    input  logic [ACC_WIDTH-1:0] wr_inc,
`ifdef CLKEN_GEN_PHASE_EN
    input  logic [ACC_WIDTH-1:0] wr_phase,
`endif
    output logic                 clk_en,
    output logic                 clk_out
);

    logic [ACC_WIDTH-1:0] shadow_inc;
    logic [ACC_WIDTH-1:0] active_inc;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] reload_val;
    logic [ACC_WIDTH:0]   sum;
    logic                 en_q;

`ifdef CLKEN_GEN_PHASE_EN
    logic [ACC_WIDTH-1:0] shadow_phase;

    always_ff @(posedge refclk) begin
        if (rst) begin
            shadow_phase <= '0;
        end else if (wr_en) begin
            shadow_phase <= wr_phase;
        end
    end

    assign reload_val = shadow_phase;
`else
    assign reload_val = '0;
`endif

    // Extra top bit captures the wrap of the accumulator; that carry is the enable.
    assign sum = {1'b0, acc} + {1'b0, active_inc};

    always_ff @(posedge refclk) begin
        if (rst) begin
            shadow_inc <= INIT_INC;
            active_inc <= INIT_INC;
            acc        <= '0;
            en_q       <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_inc <= wr_inc;
            end
            en_q <= 1'b0;
            if (reload) begin
                active_inc <= shadow_inc;
                acc        <= reload_val;
            end else if (run) begin
                acc  <= sum[ACC_WIDTH-1:0];
                en_q <= sum[ACC_WIDTH];
            end
        end
    end

    // A zero increment must stay silent even when the start phase has its MSB set.
    assign clk_en  = en_q & run;
    assign clk_out = acc[ACC_WIDTH-1] & run & (|active_inc);

endmodule

// File: rtl/clk_enable_gen.sv
// N-channel fractional clock-enable generator with atomic retune and a settle/lock flag.
// Define CLKEN_GEN_PHASE_EN to add the per-channel start phase input cfg_phase.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int                            CHANNELS    = 2,
    parameter int                            ACC_WIDTH   = 32,
    parameter int                            LOCK_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] INIT_INC    = {INC_18M_AT_50M, INC_25M2_AT_50M}
) (
    input  logic                       refclk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [sel_w(CHANNELS)-1:0] cfg_sel,
    input  logic [ACC_WIDTH-1:0]       cfg_inc,
`ifdef CLKEN_GEN_PHASE_EN
    input  logic [ACC_WIDTH-1:0]       cfg_phase,
`endif
    input  logic                       cfg_commit,
    output logic [CHANNELS-1:0]        outclk_en,
    output logic [CHANNELS-1:0]        outclk,
    output logic                       locked,
    output logic [1:0]                 dbg_state
);

    localparam int               SEL_W    = sel_w(CHANNELS);
    localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] settle_cnt;
    logic             reload;
    logic             run;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= RELOAD;
            settle_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // A commit restarts from RELOAD regardless of state, even on the SETTLE->RUN cycle.
    always_comb begin
        next_state = state;
        case (state)
            RELOAD:  next_state = SETTLE;
            SETTLE:  if (settle_cnt == CNT_LAST) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = RELOAD;
        endcase
        if (cfg_commit) begin
            next_state = RELOAD;
        end
    end

    always_comb begin
        reload    = (state == RELOAD);
        run       = (state == RUN);
        locked    = run;
        dbg_state = state;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_en;

        // Out-of-range selects match no channel and are silently dropped.
        assign wr_en = cfg_we && (cfg_sel == SEL_W'(i));

        clk_enable_gen_channel #(
            .ACC_WIDTH (ACC_WIDTH),
            .INIT_INC  (INIT_INC[i*ACC_WIDTH +: ACC_WIDTH])
        ) u_ch (
            .refclk   (refclk),
            .rst      (rst),
            .reload   (reload),
            .run      (run),
            .wr_en    (wr_en),
            .wr_inc   (cfg_inc),
`ifdef CLKEN_GEN_PHASE_EN
            .wr_phase (cfg_phase),
`endif
            .clk_en   (outclk_en[i]),
            .clk_out  (outclk[i])
        );
    end

endmodule
